anchor_l0_bbox: RTL

- Stage directly downstream of the level-0 anchor filter.
- Reads the N effective level-0 anchors, which the filter wrote to the 16-entry anchor_level0 SRAM (48-bit {x,y,z} fp16 words).
- Converts each coordinate to sign-magnitude Q9.6 fixed point and reports the axis-aligned bounding box (per-axis min/max) through a valid/ready result handshake.

---
 rtl/anchor_pkg.sv | 41 ++++
 rtl/anchor_fp16_to_fix.sv | 32 +++
 rtl/anchor_l0_bbox.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/anchor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// anchor_pkg : shared constants, FSM states and helpers for the L0 bbox stage
// Revision   : 1.0
// ----------------------------------------------------------------------------
package anchor_pkg;

  localparam int L0_DEPTH  = 16;
  localparam int L0_ADDR_W = $clog2(L0_DEPTH);
  localparam int L0_DATA_W = 48;
  localparam int FP_W      = 16;

  localparam int X_MSB = 47;
  localparam int Y_MSB = 31;
  localparam int Z_MSB = 15;

  localparam logic [4:0]  FP16_BIAS      = 5'd15;
  localparam logic [4:0]  FP16_MANT_BITS = 5'd10;
  localparam logic [4:0]  FIX_FRAC_BITS  = 5'd6;
  // value*64 == mantissa * 2^(exp - 19)
  localparam logic [4:0]  FIX_SHIFT      = FP16_BIAS + FP16_MANT_BITS - FIX_FRAC_BITS;
  localparam logic [15:0] SAT_MAG        = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Signed less-than on sign-magnitude words; -0 and +0 compare equal.
  function automatic logic sm_lt(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] va;
    logic signed [16:0] vb;
    va = a[15] ? -$signed({2'b00, a[14:0]}) : $signed({2'b00, a[14:0]});
    vb = b[15] ? -$signed({2'b00, b[14:0]}) : $signed({2'b00, b[14:0]});
    return va < vb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/anchor_fp16_to_fix.sv
`default_nettype none
// ----------------------------------------------------------------------------
// anchor_fp16_to_fix : combinational fp16 -> sign-magnitude Q9.6 converter
// Revision           : 1.0
// ----------------------------------------------------------------------------
module anchor_fp16_to_fix
  import anchor_pkg::*;
(
  input  logic [FP_W-1:0] fp,
  output logic [FP_W-1:0] fix
);

  logic [4:0]  exp_f;
  logic [10:0] mant;
  logic [26:0] wide;
  logic [14:0] mag;

  always_comb begin
    exp_f = fp[14:10];
    mant  = {exp_f != 5'd0, fp[9:0]};
    if (exp_f >= FIX_SHIFT) begin
      wide = {16'd0, mant} << (exp_f - FIX_SHIFT);
    end else begin
      wide = {16'd0, mant} >> (FIX_SHIFT - exp_f);
    end
    // Inf/NaN land here too: exponent 31 always overflows 15 bits
    mag = (wide > {11'd0, SAT_MAG}) ? SAT_MAG[14:0] : wide[14:0];
    fix = {fp[15] & (mag != 15'd0), mag};
  end

endmodule
`default_nettype wire

// File: rtl/anchor_l0_bbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// anchor_l0_bbox : scans level-0 anchors from SRAM, reports per-axis min/max
// Revision       : 1.0
// ----------------------------------------------------------------------------
module anchor_l0_bbox
  import anchor_pkg::*;
#(
  parameter int L0_ADDR_WIDTH = L0_ADDR_W,
  parameter int L0_DATA_WIDTH = L0_DATA_W,
  parameter int DATA_WIDTH    = FP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [L0_ADDR_WIDTH:0]   entry_count,
  output logic                     l0_cen_n,
  output logic                     l0_wen,
  output logic [L0_ADDR_WIDTH-1:0] l0_addr,
  input  logic [L0_DATA_WIDTH-1:0] l0_data_out,
  output logic                     busy,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     bbox_empty,
  output logic [DATA_WIDTH-1:0]    bbox_min_x,
  output logic [DATA_WIDTH-1:0]    bbox_min_y,
  output logic [DATA_WIDTH-1:0]    bbox_min_z,
  output logic [DATA_WIDTH-1:0]    bbox_max_x,
  output logic [DATA_WIDTH-1:0]    bbox_max_y,
  output logic [DATA_WIDTH-1:0]    bbox_max_z
);

  localparam int            CW    = L0_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << L0_ADDR_WIDTH);

  state_t state, state_next;

  logic [CW-1:0]            n_clamped;
  logic [CW-1:0]            n_q;
  logic [L0_ADDR_WIDTH-1:0] addr_q;
  logic                     last_addr;
  logic                     start_scan;
  logic                     show;
  logic                     drain_cnt;
  logic                     rd_pend;
  logic                     samp_valid;
  logic                     have_sample;
  logic                     empty_q;

  logic [DATA_WIDTH-1:0] conv_x, conv_y, conv_z;
  logic [DATA_WIDTH-1:0] samp_x, samp_y, samp_z;
  logic [DATA_WIDTH-1:0] min_x, min_y, min_z;
  logic [DATA_WIDTH-1:0] max_x, max_y, max_z;

  assign n_clamped = (entry_count > DEPTH) ? DEPTH : entry_count;
  assign last_addr = (({1'b0, addr_q} + CW'(1)) == n_q);

  anchor_fp16_to_fix u_conv_x (.fp(l0_data_out[X_MSB -: DATA_WIDTH]), .fix(conv_x));
  anchor_fp16_to_fix u_conv_y (.fp(l0_data_out[Y_MSB -: DATA_WIDTH]), .fix(conv_y));
  anchor_fp16_to_fix u_conv_z (.fp(l0_data_out[Z_MSB -: DATA_WIDTH]), .fix(conv_z));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    start_scan   = 1'b0;
    l0_cen_n     = 1'b1;
    l0_wen       = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    show         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        show = 1'b1;
        if (start) begin
          start_scan = 1'b1;
          state_next = (n_clamped == '0) ? HOLD : READ;
        end
      end
      READ: begin
        l0_cen_n = 1'b0;
        if (last_addr) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_next = HOLD;
      end
      HOLD: begin
        result_valid = 1'b1;
        show         = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read in cycle k -> data at k+1 (converted, registered) -> min/max at k+2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      addr_q      <= '0;
      drain_cnt   <= 1'b0;
      rd_pend     <= 1'b0;
      samp_valid  <= 1'b0;
      have_sample <= 1'b0;
      empty_q     <= 1'b0;
      samp_x      <= '0;
      samp_y      <= '0;
      samp_z      <= '0;
      min_x       <= '0;
      min_y       <= '0;
      min_z       <= '0;
      max_x       <= '0;
      max_y       <= '0;
      max_z       <= '0;
    end else begin
      rd_pend    <= (state == READ);
      samp_valid <= rd_pend;
      if (rd_pend) begin
        samp_x <= conv_x;
        samp_y <= conv_y;
        samp_z <= conv_z;
      end
      if (start_scan) begin
        n_q         <= n_clamped;
        addr_q      <= '0;
        drain_cnt   <= 1'b0;
        empty_q     <= (n_clamped == '0);
        have_sample <= 1'b0;
        min_x       <= '0;
        min_y       <= '0;
        min_z       <= '0;
        max_x       <= '0;
        max_y       <= '0;
        max_z       <= '0;
      end else begin
        if (state == READ && !last_addr) addr_q <= addr_q + L0_ADDR_WIDTH'(1);
        if (state == DRAIN) drain_cnt <= ~drain_cnt;
        if (state == HOLD && result_ready) addr_q <= '0;
        if (samp_valid) begin
          have_sample <= 1'b1;
          if (!have_sample || sm_lt(samp_x, min_x)) min_x <= samp_x;
          if (!have_sample || sm_lt(samp_y, min_y)) min_y <= samp_y;
          if (!have_sample || sm_lt(samp_z, min_z)) min_z <= samp_z;
          if (!have_sample || sm_lt(max_x, samp_x)) max_x <= samp_x;
          if (!have_sample || sm_lt(max_y, samp_y)) max_y <= samp_y;
          if (!have_sample || sm_lt(max_z, samp_z)) max_z <= samp_z;
        end
      end
    end
  end

  // Running values stay hidden while a scan is in flight
  assign l0_addr    = addr_q;
  assign bbox_empty = show & empty_q;
  assign bbox_min_x = show ? min_x : '0;
  assign bbox_min_y = show ? min_y : '0;
  assign bbox_min_z = show ? min_z : '0;
  assign bbox_max_x = show ? max_x : '0;
  assign bbox_max_y = show ? max_y : '0;
  assign bbox_max_z = show ? max_z : '0;

endmodule
`default_nettype wire
